// File: rtl/instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_encoder: scatters a signed immediate into I/S/B/J instruction bit   |
// | positions, flags unrepresentable values, tags words with an address.     |
// | Option macro: INSTR_ENCODER_RANGE_CHECK_EN (enables out_err checking).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] imm,
  input  logic [1:0]  imm_src,
  input  logic [31:0] base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err
);

  localparam logic [1:0] C_SRC_I = 2'b00;
  localparam logic [1:0] C_SRC_S = 2'b01;
  localparam logic [1:0] C_SRC_B = 2'b10;

  logic        r_s1_valid;
  logic [20:0] r_s1_imm;
  logic [1:0]  r_s1_src;
  logic [31:0] r_s1_base;
  logic        r_s1_err;
  logic        r_s2_valid;
  logic [31:0] r_s2_instr;
  logic        r_s2_err;
  logic [31:0] r_addr;

  logic        w_in_err;
  logic        w_s2_load;
  logic        w_s1_adv;
  logic        w_s1_load;
  logic [31:0] w_packed;

  function automatic logic [31:0] pack_imm(input logic [31:0] b, input logic [20:0] v,
                                           input logic [1:0] src);
    logic [31:0] w;
    w = b;
    case (src)
      C_SRC_I: w[31:20] = v[11:0];
      C_SRC_S: begin
        w[31:25] = v[11:5];
        w[11:7]  = v[4:0];
      end
      C_SRC_B: begin
        w[31]    = v[12];
        w[30:25] = v[10:5];
        w[11:8]  = v[4:1];
        w[7]     = v[11];
      end
      default: begin
        w[31]    = v[20];
        w[30:21] = v[10:1];
        w[20]    = v[11];
        w[19:12] = v[19:12];
      end
    endcase
    return w;
  endfunction

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  // Representable iff every bit above the top encoded bit matches the sign.
  always_comb begin
    w_in_err = 1'b0;
    case (imm_src)
      C_SRC_I, C_SRC_S: w_in_err = !((&imm[31:11]) || !(|imm[31:11]));
      C_SRC_B:          w_in_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      default:          w_in_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
    endcase
  end
`else
  logic w_unused_imm;
  assign w_unused_imm = &{1'b0, imm[31:21]};
  assign w_in_err     = 1'b0;
`endif

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_load;
  assign w_s1_load = !r_s1_valid || w_s1_adv;
  assign in_ready  = w_s1_load;
  assign w_packed  = pack_imm(r_s1_base, r_s1_imm, r_s1_src);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_imm   <= '0;
      r_s1_src   <= '0;
      r_s1_base  <= '0;
      r_s1_err   <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_imm  <= imm[20:0];
        r_s1_src  <= imm_src;
        r_s1_base <= base;
        r_s1_err  <= w_in_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_instr <= w_packed;
        r_s2_err   <= r_s1_err;
      end
    end
  end

  // Address wraps naturally modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= BASE_ADDR;
    end else if (r_s2_valid && out_ready) begin
      r_addr <= r_addr + ADDR_STEP;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_instr = r_s2_instr;
  assign out_err   = r_s2_err;
  assign out_addr  = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_encoder: directed and random round-trip bench for instr_encoder |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'hFFFF_FFF8;
  localparam logic [31:0] STEP = 32'd4;
  localparam int          NRND = 10000;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] imm;
  logic [1:0]  imm_src;
  logic [31:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_addr;

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  src;
    logic [31:0] base;
  } req_t;
  req_t q[$];

  instr_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .imm_src(imm_src), .base(base), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [31:0] i, input logic [1:0] s, input logic [31:0] b);
    in_valid = v;
    imm      = i;
    imm_src  = s;
    base     = b;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 2'b00, 32'h0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0 || out_addr !== BASE)
      $display("FAIL reset_state: valid=%b instr=%h err=%b addr=%h, want 0/0/0/%h",
               out_valid, out_instr, out_err, out_addr, BASE);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_ready: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    else n_pass++;
    exp_addr = BASE;
  endtask

  task automatic test_pack_i;
    @(negedge clk);
    drive(1'b1, 32'hFFFF_FFFF, 2'b00, 32'h0000_0013);
    @(negedge clk);
    drive(1'b0, 32'h0, 2'b00, 32'h0);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL pack_i_latency: out_valid=%b one edge after accept, want 0", out_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFFF0_0013 || out_err !== 1'b0 || out_addr !== exp_addr)
      $display("FAIL pack_i: valid=%b instr=%h err=%b addr=%h, want 1/fff00013/0/%h",
               out_valid, out_instr, out_err, out_addr, exp_addr);
    else n_pass++;
    exp_addr += STEP;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL pack_i_drain: out_valid=%b, want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] vi[3];
    logic [1:0]  vs[3];
    logic [31:0] vb[3];
    logic [31:0] ve[3];
    vi = '{32'd2047, 32'hFFFF_FFFC, 32'd8};
    vs = '{2'b01, 2'b10, 2'b11};
    vb = '{32'h0000_2023, 32'h0000_0063, 32'h0000_006F};
    ve = '{32'h7E00_2FA3, 32'hFE00_0EE3, 32'h0080_006F};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_instr !== ve[c-2] || out_err !== 1'b0 || out_addr !== exp_addr)
          $display("FAIL b2b_%0d: valid=%b instr=%h err=%b addr=%h, want 1/%h/0/%h",
                   c - 2, out_valid, out_instr, out_err, out_addr, ve[c-2], exp_addr);
        else n_pass++;
        exp_addr += STEP;
      end
      if (c == 5) begin
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drain: out_valid=%b, want 0", out_valid);
        else n_pass++;
      end
      if (c < 3) drive(1'b1, vi[c], vs[c], vb[c]);
      else drive(1'b0, 32'h0, 2'b00, 32'h0);
    end
  endtask

  task automatic test_errors;
    logic [31:0] vi[2];
    logic [1:0]  vs[2];
    logic [31:0] vb[2];
    logic [31:0] ve[2];
    vi = '{32'd3, 32'd2048};
    vs = '{2'b10, 2'b00};
    vb = '{32'h0000_0063, 32'h0000_0013};
    ve = '{32'h0000_0163, 32'h8000_0013};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_instr !== ve[c-2] || out_err !== RC || out_addr !== exp_addr)
          $display("FAIL err_%0d: valid=%b instr=%h err=%b addr=%h, want 1/%h/%b/%h",
                   c - 2, out_valid, out_instr, out_err, out_addr, ve[c-2], RC, exp_addr);
        else n_pass++;
        exp_addr += STEP;
      end
      if (c < 2) drive(1'b1, vi[c], vs[c], vb[c]);
      else drive(1'b0, 32'h0, 2'b00, 32'h0);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] ve[3];
    ve = '{32'h0010_0013, 32'h0020_0013, 32'h0030_0013};
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_checks++;
      if (in_ready !== (c < 2)) $display("FAIL bp_ready_%0d: in_ready=%b, want %b", c, in_ready, c < 2);
      else n_pass++;
      drive(1'b1, 32'(c + 1), 2'b00, 32'h0000_0013);
    end
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== ve[0] || out_addr !== exp_addr)
        $display("FAIL bp_hold: in_ready=%b valid=%b instr=%h addr=%h, want 0/1/%h/%h",
                 in_ready, out_valid, out_instr, out_addr, ve[0], exp_addr);
      else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready: in_ready=%b, want 1", in_ready);
    else n_pass++;
    exp_addr += STEP;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 2'b00, 32'h0);
      n_checks++;
      if (k < 3) begin
        if (out_valid !== 1'b1 || out_instr !== ve[k] || out_addr !== exp_addr)
          $display("FAIL bp_drain_%0d: valid=%b instr=%h addr=%h, want 1/%h/%h",
                   k, out_valid, out_instr, out_addr, ve[k], exp_addr);
        else n_pass++;
        exp_addr += STEP;
      end else begin
        if (out_valid !== 1'b0) $display("FAIL bp_empty: out_valid=%b, want 0", out_valid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'd5, 2'b00, 32'h0000_0013);
    @(negedge clk);
    drive(1'b1, 32'd6, 2'b00, 32'h0000_0013);
    @(negedge clk);
    drive(1'b0, 32'h0, 2'b00, 32'h0);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL mid_pre: out_valid=%b, want 1", out_valid);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_addr !== BASE || out_instr !== 32'h0)
      $display("FAIL mid_reset: valid=%b addr=%h instr=%h, want 0/%h/0", out_valid, out_addr, out_instr, BASE);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_addr = BASE;
    drive(1'b1, 32'd7, 2'b00, 32'h0000_0013);
    @(negedge clk);
    drive(1'b0, 32'h0, 2'b00, 32'h0);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0070_0013 || out_addr !== BASE)
      $display("FAIL mid_after: valid=%b instr=%h addr=%h, want 1/00700013/%h", out_valid, out_instr, out_addr, BASE);
    else n_pass++;
    exp_addr += STEP;
    @(negedge clk);
  endtask

  task automatic test_random;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic signed [31:0] t;
    logic signed [31:0] ext;
    logic [31:0] mask;
    logic merr;
    req_t e;
    while (got < NRND && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      t = $urandom;
      t = t >>> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) t[0] = 1'b0;
      drive((sent < NRND) && ($urandom_range(0, 4) != 0), t, 2'($urandom_range(0, 3)), $urandom);
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL rnd_extra: unexpected word instr=%h addr=%h", out_instr, out_addr);
        end else begin
          e = q.pop_front();
          case (e.src)
            2'b00: begin
              ext = {{20{out_instr[31]}}, out_instr[31:20]};
              mask = 32'hFFF0_0000;
              merr = ($signed(e.imm) < -2048) || ($signed(e.imm) > 2047);
            end
            2'b01: begin
              ext = {{20{out_instr[31]}}, out_instr[31:25], out_instr[11:7]};
              mask = 32'hFE00_0F80;
              merr = ($signed(e.imm) < -2048) || ($signed(e.imm) > 2047);
            end
            2'b10: begin
              ext = {{19{out_instr[31]}}, out_instr[31], out_instr[7], out_instr[30:25], out_instr[11:8], 1'b0};
              mask = 32'hFE00_0F80;
              merr = ($signed(e.imm) < -4096) || ($signed(e.imm) > 4095) || e.imm[0];
            end
            default: begin
              ext = {{11{out_instr[31]}}, out_instr[31], out_instr[19:12], out_instr[20], out_instr[30:21], 1'b0};
              mask = 32'hFFFF_F000;
              merr = ($signed(e.imm) < -1048576) || ($signed(e.imm) > 1048575) || e.imm[0];
            end
          endcase
          if (out_addr !== exp_addr || out_err !== (RC && merr) ||
              (out_instr & ~mask) !== (e.base & ~mask) || (!merr && ext !== e.imm))
            $display("FAIL rnd_%0d: src=%0d imm=%h base=%h -> instr=%h err=%b addr=%h ext=%h, want err=%b addr=%h",
                     got, e.src, e.imm, e.base, out_instr, out_err, out_addr, ext, RC && merr, exp_addr);
          else n_pass++;
        end
        exp_addr += STEP;
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back('{imm: imm, src: imm_src, base: base});
        sent++;
      end
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 2'b00, 32'h0);
    n_checks++;
    if (got != NRND || q.size() != 0)
      $display("FAIL rnd_complete: received %0d words with %0d pending, want %0d and 0", got, q.size(), NRND);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pack_i();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
